// File: rtl/sw_debounce_4b.sv
// Purpose: 2-flop synchronise and independently debounce four raw switch inputs, with per-bit change strobes.
// Latency: input steady from edge k gives a new a..d level at edge k+2+DEBOUNCE_CYCLES; strobe lasts one cycle.
// Backpressure: none; free-running conditioning stage with no ready input, so outputs are always valid.
module sw_debounce_4b #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] chg_mask,
  output logic       changed,
  output logic       busy
);

  // Last count value before a new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       stable_q;
  logic [3:0]       stable_d;
  logic [3:0]       chg_q;
  logic [3:0]       chg_d;
  logic             changed_q;
  state_e           state_q [4];
  state_e           state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];

  // Two-flop synchroniser; sw_in is asynchronous to clk, only sync2_q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic for the four identical per-bit debounce FSMs.
  always_comb begin
    stable_d = stable_q;
    chg_d    = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (sync2_q[i] != stable_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // A single matching cycle is enough: accept without counting.
              stable_d[i] = sync2_q[i];
              chg_d[i]    = 1'b1;
            end else begin
              cnt_d[i]   = CNT_W'(1);
              state_d[i] = ST_COUNTING;
            end
          end
        end
        ST_COUNTING: begin
          if (sync2_q[i] == stable_q[i]) begin
            // Input bounced back before qualifying: drop the attempt silently.
            cnt_d[i]   = '0;
            state_d[i] = ST_STABLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = sync2_q[i];
            chg_d[i]    = 1'b1;
            cnt_d[i]    = '0;
            state_d[i]  = ST_STABLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = ST_STABLE;
        end
      endcase
    end
  end

  // State, counter, stable-level and strobe registers; reset aborts any qualification in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q  <= '0;
      chg_q     <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      stable_q  <= stable_d;
      chg_q     <= chg_d;
      changed_q <= |chg_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Busy whenever any bit has a level change under qualification.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      busy = busy | (|cnt_q[i]);
    end
  end

  assign a        = stable_q[3];
  assign b        = stable_q[2];
  assign c        = stable_q[1];
  assign d        = stable_q[0];
  assign chg_mask = chg_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_sw_debounce_4b.sv
// Purpose: directed self-checking bench for sw_debounce_4b with DEBOUNCE_CYCLES=4, CNT_W=3.
// Latency: a step applied just after edge k is expected on a..d at edge k+6, strobe for one cycle.
// Backpressure: not applicable; inputs driven 1 time unit after rising edges, outputs checked there too.
module tb_sw_debounce_4b;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_in;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic [3:0] chg_mask;
  logic       changed;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int pcnt [4] = '{0, 0, 0, 0};
  int ccnt     = 0;
  int snap [4];
  int csnap;

  sw_debounce_4b #(.CNT_W(3), .DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_in    (sw_in),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .chg_mask (chg_mask),
    .changed  (changed),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe pulses per bit and of changed, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (chg_mask[i]) pcnt[i]++;
    end
    if (changed) ccnt++;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic take_snap();
    for (int i = 0; i < 4; i++) snap[i] = pcnt[i];
    csnap = ccnt;
  endtask

  initial begin
    // 1. Reset with all switches high, then release.
    rst_n = 1'b0;
    sw_in = 4'hF;
    edges(3);
    chk("rst_abcd", {4'h0, a, b, c, d}, 8'h00);
    chk("rst_chg", {4'h0, chg_mask}, 8'h00);
    chk("rst_busy", {7'h0, busy}, 8'h00);
    chk("rst_changed", {7'h0, changed}, 8'h00);
    rst_n = 1'b1;
    edges(3);
    chk("rel_busy_e3", {7'h0, busy}, 8'h01);
    edges(2);
    chk("rel_abcd_e5", {4'h0, a, b, c, d}, 8'h00);
    edges(1);
    chk("rel_abcd_e6", {4'h0, a, b, c, d}, 8'h0F);
    chk("rel_chg_e6", {4'h0, chg_mask}, 8'h0F);
    chk("rel_changed_e6", {7'h0, changed}, 8'h01);
    chk("rel_busy_e6", {7'h0, busy}, 8'h00);
    edges(1);
    chk("rel_chg_e7", {4'h0, chg_mask}, 8'h00);
    chk("rel_changed_e7", {7'h0, changed}, 8'h00);

    // 2. Clean step on a only, from an all-zero settled state.
    sw_in = 4'h0;
    edges(10);
    chk("t2_pre_abcd", {4'h0, a, b, c, d}, 8'h00);
    sw_in = 4'b1000;
    edges(5);
    chk("t2_abcd_e5", {4'h0, a, b, c, d}, 8'h00);
    edges(1);
    chk("t2_abcd_e6", {4'h0, a, b, c, d}, 8'h08);
    chk("t2_chg_e6", {4'h0, chg_mask}, 8'h08);
    chk("t2_changed_e6", {7'h0, changed}, 8'h01);
    edges(1);
    chk("t2_chg_e7", {4'h0, chg_mask}, 8'h00);
    chk("t2_changed_e7", {7'h0, changed}, 8'h00);

    // 3. Bounce on d: 2-cycle runs 1,0,1,0 then hold 1.
    take_snap();
    for (int n = 0; n < 2; n++) begin
      sw_in = 4'b1001;
      edges(2);
      sw_in = 4'b1000;
      edges(2);
    end
    sw_in = 4'b1001;
    chk("t3_nopulse_bounce", 8'(pcnt[0] - snap[0]), 8'h00);
    chk("t3_d_bounce", {7'h0, d}, 8'h00);
    edges(5);
    chk("t3_abcd_e5", {4'h0, a, b, c, d}, 8'h08);
    edges(1);
    chk("t3_abcd_e6", {4'h0, a, b, c, d}, 8'h09);
    chk("t3_chg_e6", {4'h0, chg_mask}, 8'h01);
    edges(3);
    chk("t3_pulses_d", 8'(pcnt[0] - snap[0]), 8'h01);
    chk("t3_pulses_a", 8'(pcnt[3] - snap[3]), 8'h00);

    // 4. Short glitch on b: high for 3 cycles only.
    take_snap();
    sw_in = 4'b1101;
    edges(3);
    sw_in = 4'b1001;
    edges(1);
    chk("t4_busy_mid", {7'h0, busy}, 8'h01);
    edges(6);
    chk("t4_busy_end", {7'h0, busy}, 8'h00);
    chk("t4_abcd", {4'h0, a, b, c, d}, 8'h09);
    chk("t4_pulses_b", 8'(pcnt[2] - snap[2]), 8'h00);
    chk("t4_changed", 8'(ccnt - csnap), 8'h00);

    // 5. Simultaneous step on b and d.
    sw_in = 4'h0;
    edges(10);
    chk("t5_pre_abcd", {4'h0, a, b, c, d}, 8'h00);
    take_snap();
    sw_in = 4'b0101;
    edges(5);
    chk("t5_abcd_e5", {4'h0, a, b, c, d}, 8'h00);
    edges(1);
    chk("t5_abcd_e6", {4'h0, a, b, c, d}, 8'h05);
    chk("t5_chg_e6", {4'h0, chg_mask}, 8'h05);
    chk("t5_changed_e6", {7'h0, changed}, 8'h01);
    edges(3);
    chk("t5_changed_cnt", 8'(ccnt - csnap), 8'h01);

    // 6. Reset pulse while a and c are counting.
    take_snap();
    sw_in = 4'hF;
    edges(4);
    chk("t6_busy_pre", {7'h0, busy}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_abcd", {4'h0, a, b, c, d}, 8'h00);
    chk("t6_rst_busy", {7'h0, busy}, 8'h00);
    chk("t6_rst_chg", {4'h0, chg_mask}, 8'h00);
    edges(1);
    rst_n = 1'b1;
    edges(5);
    chk("t6_abcd_e5", {4'h0, a, b, c, d}, 8'h00);
    chk("t6_nopulse_a", 8'(pcnt[3] - snap[3]), 8'h00);
    chk("t6_nopulse_c", 8'(pcnt[1] - snap[1]), 8'h00);
    edges(1);
    chk("t6_abcd_e6", {4'h0, a, b, c, d}, 8'h0F);
    chk("t6_chg_e6", {4'h0, chg_mask}, 8'h0F);
    edges(1);
    chk("t6_chg_e7", {4'h0, chg_mask}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
